// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: program counter, synchronous program ROM and the control FSM that
// drives the ACLU strobes (sel, enable, ac1, ac2).
// Optional feature: define SINGLE_STEP_EN to add the step input (single-instruction stepping).
module fetch_decode_unit #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned DATA_W   = 8,
   parameter              ROM_FILE = "memory.list"
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              load_pc,
   input  logic [ADDR_W-1:0] pc_load_val,
   input  logic              c,
   input  logic              zero,
`ifdef SINGLE_STEP_EN
   input  logic              step,
`endif
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] program_byte,
   output logic [3:0]        instr,
   output logic [3:0]        operand,
   output logic [2:0]        sel,
   output logic              enable,
   output logic              ac1,
   output logic              ac2,
   output logic              halted
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StJaddr, StHalt
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              taken_q, taken_d;
   logic [DATA_W-1:0] program_byte_q;
   logic              step_rise;

   logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];

   // Synchronous ROM read, one cycle latency, always addressed by the PC
   always_ff @(posedge clk) begin
      program_byte_q <= rom[pc_q];
   end

`ifdef SINGLE_STEP_EN
   logic step_q, step_prev_q;

   // Register step and detect its rising edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q      <= 1'b0;
         step_prev_q <= 1'b0;
      end else begin
         step_q      <= step;
         step_prev_q <= step_q;
      end
   end
   assign step_rise = step_q & ~step_prev_q;
`else
   assign step_rise = 1'b0;
`endif

   // State, PC, instruction register and latched jump decision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= '0;
         ir_q    <= '0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         taken_q <= taken_d;
      end
   end

   // Next-state logic; a step edge in IDLE launches one instruction and, with run low,
   // the end-of-instruction check returns to IDLE on its own
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      taken_d = taken_q;
      unique case (state_q)
         StIdle: begin
            if (load_pc) begin
               pc_d = pc_load_val;
            end else if (run || step_rise) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            state_d = StDecode;
         end
         StDecode: begin
            ir_d    = program_byte_q;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StExec;
         end
         StExec: begin
            state_d = run ? StFetch : StIdle;
            case (ir_q[7:4])
               4'h8: begin taken_d = 1'b1;  state_d = StJaddr; end
               4'h9: begin taken_d = c;     state_d = StJaddr; end
               4'hA: begin taken_d = ~zero; state_d = StJaddr; end
               4'hF: state_d = StHalt;
               default: ;
            endcase
         end
         StJaddr: begin
            // Address byte was read from pc during EXEC and is on program_byte now
            pc_d    = taken_q ? ADDR_W'({ir_q[3:0], program_byte_q}) : pc_q + ADDR_W'(1);
            state_d = run ? StFetch : StIdle;
         end
         StHalt: begin
            if (load_pc) begin
               pc_d    = pc_load_val;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control strobes decoded only from registered state and IR
   always_comb begin
      sel    = 3'd0;
      enable = 1'b0;
      ac1    = 1'b0;
      ac2    = 1'b0;
      if (state_q == StExec && !ir_q[7]) begin
         sel    = ir_q[6:4];
         enable = 1'b1;
         ac1    = 1'b1;
         ac2    = 1'b1;
      end
   end

   assign halted       = (state_q == StHalt);
   assign pc           = pc_q;
   assign program_byte = program_byte_q;
   assign instr        = ir_q[7:4];
   assign operand      = ir_q[3:0];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: instruction-level reference model compared against the DUT every
// cycle, plus directed programs with hand-computed expectations and a randomized run.
module tb_fetch_decode_unit;

   logic        clk = 1'b0;
   logic        rst, run, load_pc, c, zero;
   logic [11:0] pc_load_val;
`ifdef SINGLE_STEP_EN
   logic        step;
`endif
   logic [11:0] pc;
   logic [7:0]  program_byte;
   logic [3:0]  instr, operand;
   logic [2:0]  sel;
   logic        enable, ac1, ac2, halted;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [4096];

   // Reference model: 0 idle, 1 executing an instruction (m_k = cycle within it), 2 halted
   int          m_mode;
   int          m_k;
   logic [11:0] m_pc;
   logic [7:0]  m_ir;
   logic        m_taken;
   logic [7:0]  m_pb;
   logic        m_pb_ok = 1'b0;
   logic        m_s1, m_s2;

   always #5 clk = ~clk;

   fetch_decode_unit #(.ROM_FILE("")) dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .load_pc      (load_pc),
      .pc_load_val  (pc_load_val),
      .c            (c),
      .zero         (zero),
`ifdef SINGLE_STEP_EN
      .step         (step),
`endif
      .pc           (pc),
      .program_byte (program_byte),
      .instr        (instr),
      .operand      (operand),
      .sel          (sel),
      .enable       (enable),
      .ac1          (ac1),
      .ac2          (ac2),
      .halted       (halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_k     = 0;
      m_pc    = 12'h000;
      m_ir    = 8'h00;
      m_taken = 1'b0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
   endtask

   // Advance the model across one rising edge using the inputs currently applied
   task automatic model_step();
      logic       fin, rise;
      logic [3:0] op;
      m_pb    = mem[m_pc];
      m_pb_ok = 1'b1;
      if (rst) begin
         model_reset();
         return;
      end
      rise = m_s1 & ~m_s2;
      m_s2 = m_s1;
`ifdef SINGLE_STEP_EN
      m_s1 = step;
`else
      m_s1 = 1'b0;
`endif
      fin = 1'b0;
      if (m_mode == 0) begin
         if (load_pc) m_pc = pc_load_val;
         else if (run || rise) begin
            m_mode = 1;
            m_k    = 0;
         end
      end else if (m_mode == 2) begin
         if (load_pc) begin
            m_pc   = pc_load_val;
            m_mode = 0;
         end
      end else begin
         if (m_k == 0) m_k = 1;
         else if (m_k == 1) begin
            m_ir = mem[m_pc];
            m_pc = m_pc + 12'd1;
            m_k  = 2;
         end else if (m_k == 2) begin
            op = m_ir[7:4];
            if (op == 4'h8 || op == 4'h9 || op == 4'hA) begin
               m_taken = (op == 4'h8) || (op == 4'h9 && c) || (op == 4'hA && !zero);
               m_k     = 3;
            end else if (op == 4'hF) m_mode = 2;
            else fin = 1'b1;
         end else begin
            m_pc = m_taken ? {m_ir[3:0], mem[m_pc]} : m_pc + 12'd1;
            fin  = 1'b1;
         end
         if (fin) begin
            if (run) m_k = 0;
            else m_mode = 0;
         end
      end
   endtask

   task automatic check_all();
      logic alu;
      alu = (m_mode == 1) && (m_k == 2) && !m_ir[7];
      chk("pc", 32'(pc), 32'(m_pc));
      chk("instr", 32'(instr), 32'(m_ir[7:4]));
      chk("operand", 32'(operand), 32'(m_ir[3:0]));
      chk("sel", 32'(sel), alu ? 32'(m_ir[6:4]) : 32'd0);
      chk("enable", 32'(enable), 32'(alu));
      chk("ac1", 32'(ac1), 32'(alu));
      chk("ac2", 32'(ac2), 32'(alu));
      chk("halted", 32'(halted), 32'(m_mode == 2));
      if (m_pb_ok) chk("program_byte", 32'(program_byte), 32'(m_pb));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int cnt;
      rst         = 1'b1;
      run         = 1'b0;
      load_pc     = 1'b0;
      pc_load_val = 12'h000;
      c           = 1'b0;
      zero        = 1'b0;
`ifdef SINGLE_STEP_EN
      step        = 1'b0;
`endif
      for (int i = 0; i < 4096; i++) mem[i] = 8'hB0;
      mem[12'h000] = 8'h12;
      mem[12'h001] = 8'h83;
      mem[12'h002] = 8'h45;
      mem[12'h345] = 8'h80;
      mem[12'h346] = 8'h04;
      mem[12'h004] = 8'h90;
      mem[12'h005] = 8'hA0;
      mem[12'h006] = 8'h35;
      mem[12'h007] = 8'hF0;
      mem[12'h0A0] = 8'hF0;
      mem[12'hFFF] = 8'h27;
      #1;
      for (int i = 0; i < 4096; i++) dut.rom[i] = mem[i];
      model_reset();
      check_all();
      chk("reset_pc", 32'(pc), 32'h0);
      chk("reset_halted", 32'(halted), 32'h0);
      cycn(2);
      rst = 1'b0;

      // ALU op 0x12 then JMP 0x345
      run = 1'b1;
      cycn(3);
      chk("t2_sel", 32'(sel), 32'h1);
      chk("t2_operand", 32'(operand), 32'h2);
      chk("t2_enable", 32'({enable, ac1, ac2}), 32'h7);
      chk("t2_pc", 32'(pc), 32'h1);
      cyc();
      chk("t2_enable_once", 32'(enable), 32'h0);
      cycn(4);
      chk("t3_jmp_pc", 32'(pc), 32'h345);
      cycn(8);
      chk("t4_jc_not_taken_pc", 32'(pc), 32'h6);
      cycn(6);
      chk("t5_halted", 32'(halted), 32'h1);
      chk("t5_pc", 32'(pc), 32'h8);
      cycn(10);
      chk("t5_halt_hold", 32'({halted, pc}), 32'h1008);
      load_pc = 1'b1;
      pc_load_val = 12'h000;
      run = 1'b0;
      cyc();
      chk("t5_release", 32'({halted, pc}), 32'h0000);
      pc_load_val = 12'h004;
      cyc();
      load_pc = 1'b0;
      c = 1'b1;
      run = 1'b1;
      cycn(5);
      chk("t4_jc_taken_pc", 32'(pc), 32'h0A0);
      cycn(3);
      chk("t4_halt_a1", 32'({halted, pc}), 32'h10A1);

      // Wrap from 0xFFF
      load_pc = 1'b1;
      pc_load_val = 12'hFFF;
      run = 1'b0;
      cyc();
      load_pc = 1'b0;
      run = 1'b1;
      cycn(3);
      chk("t6_wrap_pc", 32'(pc), 32'h000);
      chk("t6_wrap_sel", 32'(sel), 32'h2);
      run = 1'b0;
      cyc();

      // Reset in the middle of an ALU EXEC
      run = 1'b1;
      cycn(3);
      chk("t1_in_exec", 32'(enable), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("t1_pc", 32'(pc), 32'h0);
      chk("t1_strobes", 32'({enable, ac1, ac2}), 32'h0);
      check_all();
      run = 1'b0;
      cyc();
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (enable) cnt++;
      end
      chk("t1_no_enable_after", 32'(cnt), 32'h0);

`ifdef SINGLE_STEP_EN
      // One step pulse with run low executes exactly one instruction
      step = 1'b1;
      cyc();
      step = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (enable) cnt++;
      end
      chk("t6_step_enables", 32'(cnt), 32'h1);
      chk("t6_step_pc", 32'(pc), 32'h1);
`endif

      // Randomized program and inputs
      rst = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 8'($urandom);
         dut.rom[i] = mem[i];
      end
      cyc();
      rst = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         run         = ($urandom_range(0, 9) < 8);
         load_pc     = ($urandom_range(0, 19) == 0);
         pc_load_val = 12'($urandom);
         c           = 1'($urandom);
         zero        = 1'($urandom);
`ifdef SINGLE_STEP_EN
         step        = ($urandom_range(0, 2) == 0);
`endif
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            check_all();
            cyc();
            rst = 1'b0;
         end else begin
            cyc();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
